// File: rtl/mul_div_unit.sv
// mul_div_unit
// Multi-cycle multiply/divide unit that owns the architectural HI/LO pair.
// Multiply is iterative shift-add and divide is iterative restoring.
// Signed operations run on magnitudes and are sign-corrected in a final FIX cycle.
//
// Optional feature macro: MDU_FAST_MUL_EN
//   defined   : MULT/MULTU use a single-cycle combinational multiplier (IDLE -> FIX)
//   undefined : iterative shift-add multiply
//
// Ports:
//   clock      rising-edge clock
//   reset_n    asynchronous active-low reset
//   op_valid   operation request
//   op_ready   unit can accept (!busy && !cancel)
//   op_code    000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x reserved
//   op_a       rs: dividend / multiplicand / move source
//   op_b       rt: divisor / multiplier
//   cancel     abort the in-flight operation (flush)
//   busy       iterative operation in flight
//   done       one-cycle pulse, hi/lo updated on the same edge
//   div_zero   sticky: last divide had op_b == 0
//   hi, lo     HI / LO registers
module mul_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [2:0]       op_code,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    // Two's-complement negation at operand width, applied when en is set.
    function automatic logic [WIDTH-1:0] cond_neg_w(input logic [WIDTH-1:0] v, input logic en);
        logic [WIDTH-1:0] r;
        if (en) begin
            r = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Two's-complement negation at product width, applied when en is set.
    function automatic logic [2*WIDTH-1:0] cond_neg_2w(input logic [2*WIDTH-1:0] v, input logic en);
        logic [2*WIDTH-1:0] r;
        if (en) begin
            r = ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
        end else begin
            r = v;
        end
        return r;
    endfunction

    state_t               state_r;
    state_t               state_nxt_s;
    logic [CNT_W-1:0]     cnt_r;
    logic [2*WIDTH-1:0]   acc_r;      // product accumulator; low half is dividend/quotient
    logic [WIDTH:0]       rem_r;      // partial remainder
    logic [WIDTH-1:0]     opnd_r;     // multiplicand or divisor magnitude
    logic [WIDTH-1:0]     dvd_r;      // unmodified dividend for divide-by-zero result
    logic                 is_div_r;
    logic                 res_neg_r;
    logic                 rem_neg_r;
    logic                 dz_pend_r;
    logic [WIDTH-1:0]     hi_r;
    logic [WIDTH-1:0]     lo_r;
    logic                 done_r;
    logic                 div_zero_r;

    logic                 accept_s;
    logic                 is_mul_op_s;
    logic                 is_div_op_s;
    logic                 signed_op_s;
    logic                 a_neg_s;
    logic                 b_neg_s;
    logic [WIDTH-1:0]     a_abs_s;
    logic [WIDTH-1:0]     b_abs_s;
    logic [WIDTH:0]       mul_sum_s;
    logic [2*WIDTH-1:0]   mul_next_s;
    logic [WIDTH+1:0]     div_shift_s;
    logic [WIDTH+1:0]     div_trial_s;
    logic                 div_ge_s;
    logic [WIDTH:0]       div_rem_next_s;
    logic [WIDTH-1:0]     div_q_next_s;
    logic [2*WIDTH-1:0]   prod_s;
    logic [WIDTH-1:0]     quot_s;
    logic [WIDTH-1:0]     remd_s;
`ifdef MDU_FAST_MUL_EN
    logic [2*WIDTH-1:0]   fast_prod_s;
`endif

    assign busy     = (state_r != ST_IDLE);
    assign op_ready = !busy && !cancel;
    assign done     = done_r;
    assign div_zero = div_zero_r;
    assign hi       = hi_r;
    assign lo       = lo_r;

    assign accept_s    = op_valid && op_ready;
    assign is_mul_op_s = (op_code == OP_MULT) || (op_code == OP_MULTU);
    assign is_div_op_s = (op_code == OP_DIV)  || (op_code == OP_DIVU);
    // Even codes among the arithmetic ops are the signed variants.
    assign signed_op_s = (is_mul_op_s || is_div_op_s) && !op_code[0];
    assign a_neg_s     = signed_op_s && op_a[WIDTH-1];
    assign b_neg_s     = signed_op_s && op_b[WIDTH-1];
    assign a_abs_s     = cond_neg_w(op_a, a_neg_s);
    assign b_abs_s     = cond_neg_w(op_b, b_neg_s);

    // Shift-add step: add the multiplicand into the upper half when the
    // current multiplier bit is set, then shift the whole accumulator right.
    assign mul_sum_s  = {1'b0, acc_r[2*WIDTH-1:WIDTH]}
                      + (acc_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
    assign mul_next_s = {mul_sum_s, acc_r[WIDTH-1:1]};

    // Restoring step: the partial remainder is always below the divisor,
    // so the shifted value fits and the top bit of the trial is its sign.
    assign div_shift_s    = {rem_r, acc_r[WIDTH-1]};
    assign div_trial_s    = div_shift_s - {2'b00, opnd_r};
    assign div_ge_s       = ~div_trial_s[WIDTH+1];
    assign div_rem_next_s = div_ge_s ? div_trial_s[WIDTH:0] : div_shift_s[WIDTH:0];
    assign div_q_next_s   = {acc_r[WIDTH-2:0], div_ge_s};

    assign prod_s = cond_neg_2w(acc_r, res_neg_r);
    assign quot_s = cond_neg_w(acc_r[WIDTH-1:0], res_neg_r);
    assign remd_s = cond_neg_w(rem_r[WIDTH-1:0], rem_neg_r);

`ifdef MDU_FAST_MUL_EN
    assign fast_prod_s = {{WIDTH{1'b0}}, a_abs_s} * {{WIDTH{1'b0}}, b_abs_s};
`endif

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; cancel forces IDLE from any busy state.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && is_mul_op_s) begin
`ifdef MDU_FAST_MUL_EN
                    state_nxt_s = ST_FIX;
`else
                    state_nxt_s = ST_RUN;
`endif
                end else if (accept_s && is_div_op_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cancel) begin
                    state_nxt_s = ST_IDLE;
                end else if (cnt_r == {CNT_W{1'b0}}) begin
                    state_nxt_s = ST_FIX;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_FIX: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Datapath: operand capture, iteration, sign-corrected writeback.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r      <= {CNT_W{1'b0}};
            acc_r      <= {(2*WIDTH){1'b0}};
            rem_r      <= {(WIDTH+1){1'b0}};
            opnd_r     <= {WIDTH{1'b0}};
            dvd_r      <= {WIDTH{1'b0}};
            is_div_r   <= 1'b0;
            res_neg_r  <= 1'b0;
            rem_neg_r  <= 1'b0;
            dz_pend_r  <= 1'b0;
            hi_r       <= {WIDTH{1'b0}};
            lo_r       <= {WIDTH{1'b0}};
            done_r     <= 1'b0;
            div_zero_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        case (op_code)
                            OP_MTHI: begin
                                hi_r   <= op_a;
                                done_r <= 1'b1;
                            end
                            OP_MTLO: begin
                                lo_r   <= op_a;
                                done_r <= 1'b1;
                            end
                            OP_MULT, OP_MULTU: begin
                                opnd_r    <= a_abs_s;
                                rem_r     <= {(WIDTH+1){1'b0}};
                                is_div_r  <= 1'b0;
                                res_neg_r <= a_neg_s ^ b_neg_s;
                                rem_neg_r <= 1'b0;
                                cnt_r     <= CNT_W'(WIDTH - 1);
`ifdef MDU_FAST_MUL_EN
                                acc_r     <= fast_prod_s;
`else
                                acc_r     <= {{WIDTH{1'b0}}, b_abs_s};
`endif
                            end
                            OP_DIV, OP_DIVU: begin
                                opnd_r     <= b_abs_s;
                                acc_r      <= {{WIDTH{1'b0}}, a_abs_s};
                                rem_r      <= {(WIDTH+1){1'b0}};
                                dvd_r      <= op_a;
                                is_div_r   <= 1'b1;
                                res_neg_r  <= a_neg_s ^ b_neg_s;
                                rem_neg_r  <= a_neg_s;
                                dz_pend_r  <= (op_b == {WIDTH{1'b0}});
                                div_zero_r <= 1'b0;
                                cnt_r      <= CNT_W'(WIDTH - 1);
                            end
                            default: begin
                                done_r <= 1'b0;
                            end
                        endcase
                    end
                end
                ST_RUN: begin
                    if (!cancel) begin
                        if (is_div_r) begin
                            acc_r <= {acc_r[2*WIDTH-1:WIDTH], div_q_next_s};
                            rem_r <= div_rem_next_s;
                        end else begin
                            acc_r <= mul_next_s;
                        end
                        if (cnt_r != {CNT_W{1'b0}}) begin
                            cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
                ST_FIX: begin
                    if (!cancel) begin
                        done_r <= 1'b1;
                        if (is_div_r && dz_pend_r) begin
                            hi_r       <= dvd_r;
                            lo_r       <= {WIDTH{1'b1}};
                            div_zero_r <= 1'b1;
                        end else if (is_div_r) begin
                            hi_r <= remd_s;
                            lo_r <= quot_s;
                        end else begin
                            hi_r <= prod_s[2*WIDTH-1:WIDTH];
                            lo_r <= prod_s[WIDTH-1:0];
                        end
                    end
                end
                default: begin
                    done_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit (WIDTH=32).
// Stimulus pushes the expected hi/lo/div_zero/latency into a scoreboard queue;
// a monitor pops and compares on every done pulse. Latency is counted in
// rising edges with the accept edge counted as the first.
module tb_mul_div_unit;

    localparam int W       = 32;
    localparam int DIV_LAT = W + 2;
`ifdef MDU_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = W + 2;
`endif
    localparam int MT_LAT  = 1;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         op_valid = 1'b0;
    logic         op_ready;
    logic [2:0]   op_code = 3'b000;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         cancel = 1'b0;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    mul_div_unit #(.WIDTH(W)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .op_code  (op_code),
        .op_a     (op_a),
        .op_b     (op_b),
        .cancel   (cancel),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           lat;
        int           acc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    logic         m_dz = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected result.
    exp_t e;
    always @(negedge clock) begin
        if (reset_n && done) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 expected no done (hi=%h lo=%h)", hi, lo);
            end else begin
                e = sb.pop_front();
                chk("hi", {32'h0, hi}, {32'h0, e.hi});
                chk("lo", {32'h0, lo}, {32'h0, e.lo});
                chk("div_zero", {63'h0, div_zero}, {63'h0, e.dz});
                chk("latency", 64'(cyc - e.acc + 1), 64'(e.lat));
                chk("ready_in_done", {63'h0, op_ready}, 64'h1);
            end
        end
    end

    // Issue one op; if exp_done, push its expected result after the accept edge.
    task automatic issue(input logic [2:0] code, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit exp_done, input logic [W-1:0] ehi, input logic [W-1:0] elo,
                         input logic edz, input int lat);
        int waited = 0;
        @(negedge clock);
        while (!op_ready && waited < 200) begin
            @(negedge clock);
            waited++;
        end
        if (!op_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: got op_ready=0 expected 1");
        end else begin
            op_valid = 1'b1;
            op_code  = code;
            op_a     = a;
            op_b     = b;
            @(posedge clock);
            #1;
            op_valid = 1'b0;
            op_a     = ~a;   // operands must already be latched
            op_b     = ~b;
            if (exp_done) sb.push_back('{ehi, elo, edz, lat, cyc});
        end
    endtask

    task automatic wait_empty();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got %0d pending results expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic run_op(input logic [2:0] code, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edz,
                          input int lat);
        m_hi = ehi;
        m_lo = elo;
        m_dz = edz;
        issue(code, a, b, 1'b1, ehi, elo, edz, lat);
        wait_empty();
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, "_hi"}, {32'h0, hi}, {32'h0, m_hi});
        chk({tag, "_lo"}, {32'h0, lo}, {32'h0, m_lo});
        chk({tag, "_dz"}, {63'h0, div_zero}, {63'h0, m_dz});
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clock);
        #2;
        chk("rst_busy", {63'h0, busy}, 64'h0);
        chk("rst_done", {63'h0, done}, 64'h0);
        chk("rst_ready", {63'h0, op_ready}, 64'h1);
        chk_regs("rst");
        @(negedge clock);
        reset_n = 1'b1;

        // Multiplies
        run_op(3'b000, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, MUL_LAT);
        run_op(3'b001, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 1'b0, MUL_LAT);
        run_op(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, MUL_LAT);
        run_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, MUL_LAT);

        // Divides, including sign combinations and most-negative / -1
        run_op(3'b010, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, DIV_LAT);
        run_op(3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, DIV_LAT);
        run_op(3'b010, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002, 1'b0, DIV_LAT);
        run_op(3'b010, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, DIV_LAT);

        // Divide by zero, sticky flag across MTLO, cleared by next divide
        run_op(3'b011, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, 1'b1, DIV_LAT);
        run_op(3'b101, 32'hAAAA5555, 32'h00000000, 32'h00000007, 32'hAAAA5555, 1'b1, MT_LAT);
        run_op(3'b011, 32'h00000009, 32'h00000003, 32'h00000000, 32'h00000003, 1'b0, DIV_LAT);
        run_op(3'b010, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1, DIV_LAT);
        run_op(3'b100, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 1'b1, MT_LAT);

        // cancel in IDLE blocks acceptance
        @(negedge clock);
        cancel = 1'b1; op_valid = 1'b1; op_code = 3'b101; op_a = 32'hDEADBEEF;
        #1;
        chk("ready_cancel_idle", {63'h0, op_ready}, 64'h0);
        @(negedge clock);
        cancel = 1'b0; op_valid = 1'b0;
        repeat (2) @(negedge clock);
        chk_regs("cancel_idle");

        // Reserved op: accepted, nothing happens
        issue(3'b110, 32'h0BADF00D, 32'h00000001, 1'b0, '0, '0, 1'b0, 0);
        repeat (3) @(negedge clock);
        chk("reserved_busy", {63'h0, busy}, 64'h0);
        chk_regs("reserved");

        // cancel mid-RUN at accept+10; accept of the divide clears div_zero
        m_dz = 1'b0;
        issue(3'b011, 32'd100, 32'd7, 1'b0, '0, '0, 1'b0, 0);
        repeat (9) @(posedge clock);
        @(negedge clock);
        chk("busy_run", {63'h0, busy}, 64'h1);
        cancel = 1'b1;
        @(negedge clock);
        cancel = 1'b0;
        #1;
        chk("busy_after_cancel", {63'h0, busy}, 64'h0);
        chk("ready_after_cancel", {63'h0, op_ready}, 64'h1);
        repeat (W + 4) @(negedge clock);
        chk_regs("cancel_run");

        // cancel coinciding with the FIX edge suppresses writeback
        issue(3'b011, 32'd100, 32'd7, 1'b0, '0, '0, 1'b0, 0);
        repeat (W) @(posedge clock);
        @(negedge clock);
        cancel = 1'b1;
        @(negedge clock);
        cancel = 1'b0;
        repeat (4) @(negedge clock);
        chk("busy_cancel_fix", {63'h0, busy}, 64'h0);
        chk_regs("cancel_fix");

        run_op(3'b011, 32'd100, 32'd7, 32'h00000002, 32'h0000000E, 1'b0, DIV_LAT);

        // Asynchronous reset between edges in the middle of RUN
        issue(3'b000, 32'd5, 32'd5, 1'b0, '0, '0, 1'b0, 0);
        repeat (5) @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        m_hi = '0; m_lo = '0; m_dz = 1'b0;
        chk("async_rst_busy", {63'h0, busy}, 64'h0);
        chk_regs("async_rst");
        @(negedge clock);
        reset_n = 1'b1;
        run_op(3'b000, 32'd2, 32'd3, 32'h00000000, 32'h00000006, 1'b0, MUL_LAT);

        repeat (3) @(negedge clock);
        chk("sb_empty", 64'(sb.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Parametrised multi-cycle multiply/divide unit that owns the architectural HI/LO register pair.
- Sits beside the execute-stage ALU. Execute issues MULT/MULTU/DIV/DIVU/MTHI/MTLO through a valid/ready handshake, stalls on busy, and reads hi/lo directly for MFHI/MFLO.
- Multiply is iterative shift-add; divide is iterative restoring; signed operations are sign-corrected in a final cycle.

Parameters:
- WIDTH, 32: operand width; hi and lo are each WIDTH bits. Legal range 8..64.
- CNT_W, $clog2(WIDTH)+1: iteration counter width. Derived; must not be overridden.

Ports:
- clock, input, 1: rising-edge clock.
- reset_n, input, 1: asynchronous, active-low reset.
- op_valid, input, 1: operation request.
- op_ready, output, 1: unit can accept; equals !busy && !cancel.
- op_code, input, 3: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 reserved.
- op_a, input, WIDTH: rs (dividend / multiplicand / MT source).
- op_b, input, WIDTH: rt (divisor / multiplier).
- cancel, input, 1: aborts the in-flight operation (branch flush).
- busy, output, 1: iterative operation in flight.
- done, output, 1: one-cycle pulse; hi/lo updated on the same edge.
- div_zero, output, 1: sticky until next accepted DIV/DIVU; last divide had op_b==0.
- hi, output, WIDTH: HI register.
- lo, output, WIDTH: LO register.

Behaviour:
- Reset (async, reset_n low): state=IDLE; hi=0, lo=0, busy=0, done=0, div_zero=0; internal accumulators and counter cleared. Reset asserted mid-operation discards the operation.
- Accept: op_valid && op_ready at a rising edge. Operands and op_code are latched; later changes on op_a/op_b have no effect.
- MTHI/MTLO: write op_a to hi or lo on the accept edge. busy stays 0; done pulses the next cycle.
- Reserved op_code: accepted, no state change, no done.
- FSM states: IDLE, RUN, FIX.
  - IDLE -> RUN on accepted MULT/MULTU/DIV/DIVU. Signed ops latch absolute values plus result sign and remainder sign.
  - RUN: one iteration per cycle for exactly WIDTH cycles; counter counts WIDTH-1 down to 0.
    - Multiply: 2*WIDTH-bit product accumulator, add-and-shift.
    - Divide: restoring trial subtract of a WIDTH+1-bit partial remainder.
  - RUN -> FIX when counter==0.
  - FIX: apply two's-complement negation (quotient sign = sign(a)^sign(b); remainder sign = sign(a); product sign = sign(a)^sign(b)). Write the result: multiply -> {hi,lo}=product; divide -> lo=quotient, hi=remainder. Assert done. Go to IDLE.
- Latency: done asserted and hi/lo valid exactly WIDTH+2 rising edges after the accept edge.
- busy: high from the edge after accept through FIX; low in the done cycle. A new op may be accepted in the done cycle.
- Divide by zero: no trap. hi=dividend (op_a unmodified), lo=all ones, div_zero=1, same latency.
- DIV of most-negative by -1: lo=most-negative, hi=0, no flag.
- cancel:
  - In RUN/FIX: return to IDLE next edge; hi/lo/div_zero unchanged; no done.
  - In IDLE: op_ready=0, so a simultaneous op_valid is not accepted.
  - cancel on the FIX edge: cancel wins; no writeback.
- Widths: all arithmetic is internal at WIDTH+1 / 2*WIDTH bits; no truncation before writeback.

Optional Feature:
- Macro: MDU_FAST_MUL_EN.
- Defined: MULT/MULTU use a single-cycle combinational multiplier. IDLE -> FIX directly, so done arrives 2 edges after accept. Divide is unchanged.
- Undefined: iterative shift-add multiply with WIDTH+2 latency, as above.

Test Plan:
- MULT op_a=FFFFFFFD (-3), op_b=00000005 -> done at accept+34 edges; hi=FFFFFFFF, lo=FFFFFFF1.
- MULTU op_a=FFFFFFFF, op_b=00000002 -> hi=00000001, lo=FFFFFFFE. With MDU_FAST_MUL_EN: same values, done at accept+2.
- DIV op_a=FFFFFFF9 (-7), op_b=00000002 -> lo=FFFFFFFD, hi=FFFFFFFF. Then DIV 80000000 / FFFFFFFF -> lo=80000000, hi=00000000, div_zero=0.
- DIVU op_a=00000007, op_b=00000000 -> hi=00000007, lo=FFFFFFFF, div_zero=1. Next DIVU 9/3 clears div_zero; result lo=3, hi=0.
- MTHI 12345678, then DIVU started and cancel asserted at accept+10 -> no done; hi=12345678 retained; op_ready=1 one cycle after cancel drops.
- reset_n pulsed low mid-RUN (asynchronously, between edges) -> hi=lo=0, busy=0 immediately; a following MULT 2*3 gives lo=6, hi=0.
